// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates an IFU and an LSU onto one memory port, one transaction outstanding.
// Define MEM_ARBITER_RR_EN for round-robin tie-break; otherwise LSU wins every tie.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_resp_valid,
  output logic [DATA_W-1:0]   ifu_rdata,

  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic                lsu_wen,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_resp_valid,
  output logic [DATA_W-1:0]   lsu_rdata,

  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int MASK_W = DATA_W / 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RESP
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic                r_owner_lsu;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_wen;
  logic [DATA_W-1:0]   r_wdata;
  logic [MASK_W-1:0]   r_wmask;

  logic                w_idle;
  logic                w_tie_lsu;
  logic                w_grant_ifu;
  logic                w_grant_lsu;
  logic                w_accept;

`ifdef MEM_ARBITER_RR_EN
  // Tie preference flips to whichever requester did not win the last accept.
  logic r_pref_lsu;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pref_lsu <= 1'b0;
    end else if (w_accept) begin
      r_pref_lsu <= w_grant_ifu;
    end
  end

  assign w_tie_lsu = r_pref_lsu;
`else
  assign w_tie_lsu = 1'b1;
`endif

  // Ready is combinational from state, so it is gated by rst to stay low throughout reset.
  assign w_idle      = (r_state == ST_IDLE) && !rst;
  assign w_grant_lsu = w_idle && lsu_req_valid && (!ifu_req_valid || w_tie_lsu);
  assign w_grant_ifu = w_idle && ifu_req_valid && (!lsu_req_valid || !w_tie_lsu);
  assign w_accept    = w_grant_ifu || w_grant_lsu;

  assign ifu_req_ready = w_grant_ifu;
  assign lsu_req_ready = w_grant_lsu;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    mem_req_valid  = 1'b0;
    ifu_resp_valid = 1'b0;
    lsu_resp_valid = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) begin
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        if (mem_resp_valid) begin
          ifu_resp_valid = !r_owner_lsu;
          lsu_resp_valid = r_owner_lsu;
          w_state_nxt    = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner_lsu <= 1'b0;
      r_addr      <= '0;
      r_wen       <= 1'b0;
      r_wdata     <= '0;
      r_wmask     <= '0;
    end else if (w_accept) begin
      r_owner_lsu <= w_grant_lsu;
      r_addr      <= w_grant_lsu ? lsu_addr : ifu_addr;
      r_wen       <= w_grant_lsu && lsu_wen;
      r_wdata     <= w_grant_lsu ? lsu_wdata : '0;
      r_wmask     <= w_grant_lsu ? lsu_wmask : '0;
    end
  end

  assign mem_addr  = r_addr;
  assign mem_wen   = r_wen;
  assign mem_wdata = r_wdata;
  assign mem_wmask = r_wmask;

  assign ifu_rdata = mem_rdata;
  assign lsu_rdata = mem_rdata;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32: address width of all address ports.
REQ-002 Parameter DATA_W, default 32: data width; write mask width is DATA_W/8.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 ifu_req_valid  input  1  fetch request present.
REQ-006 ifu_req_ready  output  1  fetch request accepted this cycle when high with valid.
REQ-007 ifu_addr  input  ADDR_W  fetch address.
REQ-008 ifu_resp_valid  output  1  fetch read data valid, one-cycle pulse.
REQ-009 ifu_rdata  output  DATA_W  fetch read data.
REQ-010 lsu_req_valid  input  1  load/store request present.
REQ-011 lsu_req_ready  output  1  load/store request accepted this cycle when high with valid.
REQ-012 lsu_addr  input  ADDR_W  load/store address.
REQ-013 lsu_wen  input  1  1 = store, 0 = load.
REQ-014 lsu_wdata  input  DATA_W  store data.
REQ-015 lsu_wmask  input  DATA_W/8  store byte enables.
REQ-016 lsu_resp_valid  output  1  load data ready or store done, one-cycle pulse.
REQ-017 lsu_rdata  output  DATA_W  load data.
REQ-018 mem_req_valid  output  1  request to the shared memory port.
REQ-019 mem_req_ready  input  1  memory accepts request when high with valid.
REQ-020 mem_addr / mem_wen / mem_wdata / mem_wmask  output  ADDR_W / 1 / DATA_W / DATA_W/8  registered payload of the granted request.
REQ-021 mem_resp_valid  input  1  memory response present (arbitrary latency >= 1 cycle).
REQ-022 mem_rdata  input  DATA_W  memory read data.

Function
REQ-023 FSM states: IDLE, REQ, RESP; at most one transaction outstanding.
REQ-024 ifu_req_ready and lsu_req_ready are high only in IDLE, and only for the winning requester; the loser sees ready low.
REQ-025 IDLE: on accepted handshake, latch owner plus addr/wen/wdata/wmask (IFU: wen=0, wmask=0, wdata=0), go to REQ next cycle.
REQ-026 REQ: mem_req_valid=1 with stable payload until mem_req_ready; on handshake go to RESP.
REQ-027 RESP: mem_req_valid=0; on mem_resp_valid, pulse owner's resp_valid in the same cycle with rdata = mem_rdata (combinational pass-through); go to IDLE.
REQ-028 Non-owner resp_valid stays 0; both rdata outputs drive mem_rdata, qualified only by their resp_valid.
REQ-029 mem_resp_valid in IDLE or REQ is ignored; no state change, no upstream pulse.
REQ-030 Minimum round trip: accept at cycle N, mem_req_valid at N+1, resp at N+2 earliest, next accept at N+3.
REQ-031 Store responses pulse lsu_resp_valid identically to loads.

Reset
REQ-032 rst asserted, at any time, forces IDLE immediately; mem_req_valid, both req_ready, both resp_valid = 0; latched payload = 0; priority pointer = IFU preferred.
REQ-033 A transaction in flight at reset is dropped; no response is delivered after reset deasserts.

Configuration
REQ-034 Macro MEM_ARBITER_RR_EN defined: round-robin; on a tie, the requester not granted last wins; pointer updates on each accept.
REQ-035 Macro undefined: fixed priority, LSU always wins on a tie; no pointer state.

Verification
REQ-036 IFU only, addr 0x80000000, mem ready at once, resp after 1 cycle data 0x00100073 -> mem_req_valid at N+1, ifu_resp_valid pulse at N+2 with ifu_rdata=0x00100073, lsu_resp_valid=0 throughout.
REQ-037 Simultaneous IFU 0x80000004 and LSU store 0x80001000 data 0xDEADBEEF mask 0xF, fixed priority -> LSU granted first, mem_wen=1, then IFU granted in the next IDLE.
REQ-038 MEM_ARBITER_RR_EN, both valid continuously for 4 transactions -> grant order IFU, LSU, IFU, LSU.
REQ-039 mem_req_ready held low 5 cycles -> mem_req_valid and payload stable for all 5 cycles; no upstream ready asserted.
REQ-040 rst asserted in RESP, then mem_resp_valid arrives -> no resp_valid pulse; state IDLE; new request accepted normally.
REQ-041 Spurious mem_resp_valid in IDLE -> no output change.
